// File: rtl/score_record_infinity_pkg.sv
// score_record_infinity_pkg: shared FSM encoding, table geometry and display constants
package score_record_infinity_pkg;
    localparam int REC_DEPTH = 3;
    localparam int SCORE_W = 6;
    localparam logic [3:0] NIB_PAD = 4'h0;
    typedef enum logic [1:0] {IDLE, CAPTURE, INSERT, SHOW} state_t;
endpackage

// File: rtl/bin2bcd_6.sv
// bin2bcd_6: combinational 6-bit binary to two BCD digits (0..63)
module bin2bcd_6
    import score_record_infinity_pkg::*;
(
    input  logic [SCORE_W-1:0] bin_i,
    output logic [3:0]         tens_o,
    output logic [3:0]         ones_o
);
    assign tens_o = 4'(bin_i / 6'd10);
    assign ones_o = 4'(bin_i % 6'd10);
endmodule

// File: rtl/score_record_infinity.sv
// score_record_infinity: top-3 score table for infinity mode with rank display and hold-to-erase
module score_record_infinity
    import score_record_infinity_pkg::*;
#(
    parameter int CLR_HOLD     = 100_000_000,
    parameter int SHOW_DEFAULT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gameover_infinity,
    input  logic [SCORE_W-1:0]  score_infinity,
    input  logic                btn_show,
    input  logic                btn_return,
    output logic [15:0]         seg_record,
    output logic [15:0]         led_record,
    output logic                new_record,
    output logic                busy
);
    localparam logic [1:0]  RANK_DEF  = 2'(SHOW_DEFAULT);
    localparam logic [1:0]  RANK_LAST = 2'(REC_DEPTH - 1);
    localparam logic [31:0] HOLD_MAX  = 32'(CLR_HOLD - 1);
    localparam logic [15:0] SEG_RST   = {4'(SHOW_DEFAULT + 1), NIB_PAD, 8'h00};
    localparam logic [15:0] LED_RST   = 16'd1 << SHOW_DEFAULT;

    state_t             state_q, state_d;
    logic               gov_prev_q, show_prev_q, ret_prev_q;
    logic [SCORE_W-1:0] cap_q, cap_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, sel;
    logic [1:0]         cnt_q, cnt_d, rank_q, rank_d;
    logic [31:0]        hold_q, hold_d;
    logic               new_q, new_d;
    logic [15:0]        seg_d, led_d;
    logic [3:0]         tens, ones;
    logic               gov_rise, show_rise, ret_rise, idle_show, clr, gt1, gt2, gt3;

    assign gov_rise  = gameover_infinity & ~gov_prev_q;
    assign show_rise = btn_show & ~show_prev_q;
    assign ret_rise  = btn_return & ~ret_prev_q;
    assign idle_show = (state_q == IDLE) || (state_q == SHOW);
    assign clr       = idle_show && btn_return && (hold_q == HOLD_MAX);
    // Empty slots accept any score so an unfilled table always takes the capture
    assign gt1 = (cap_q > r1_q) || (cnt_q == 2'd0);
    assign gt2 = (cap_q > r2_q) || (cnt_q < 2'd2);
    assign gt3 = (cap_q > r3_q) || (cnt_q != 2'd3);
    assign sel = (rank_q >= cnt_q) ? '0 : (rank_q == 2'd0) ? r1_q : (rank_q == 2'd1) ? r2_q : r3_q;
    assign busy       = (state_q == CAPTURE) || (state_q == INSERT);
    assign new_record = new_q;

    bin2bcd_6 u_bcd (.bin_i(sel), .tens_o(tens), .ones_o(ones));

    // Next-state: FSM, table insertion, rank selection, hold-to-erase and display words
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        cnt_d   = cnt_q;
        rank_d  = rank_q;
        new_d   = ret_rise ? 1'b0 : new_q;
        hold_d  = (idle_show && btn_return) ? ((hold_q == HOLD_MAX) ? hold_q : hold_q + 32'd1) : 32'd0;
        seg_d   = {4'({2'b00, rank_q}) + 4'd1, NIB_PAD, tens, ones};
        led_d   = {new_q, 12'h000, rank_q == 2'd2, rank_q == 2'd1, rank_q == 2'd0};
        case (state_q)
            IDLE, SHOW: begin
                if (show_rise) rank_d = (rank_q == RANK_LAST) ? 2'd0 : rank_q + 2'd1;
                if (clr) begin
                    state_d = IDLE;
                    r1_d    = '0;
                    r2_d    = '0;
                    r3_d    = '0;
                    cnt_d   = 2'd0;
                    new_d   = 1'b0;
                end else if (gov_rise) state_d = CAPTURE;
                else if (state_q == SHOW && ret_rise) state_d = IDLE;
            end
            CAPTURE: begin
                cap_d   = score_infinity;
                state_d = INSERT;
            end
            INSERT: begin
                if (gt1) {r1_d, r2_d, r3_d} = {cap_q, r1_q, r2_q};
                else if (gt2) {r2_d, r3_d} = {cap_q, r2_q};
                else if (gt3) r3_d = cap_q;
                cnt_d   = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
                new_d   = gt1;
                rank_d  = RANK_DEF;
                state_d = SHOW;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any capture in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gov_prev_q  <= 1'b0;
            show_prev_q <= 1'b0;
            ret_prev_q  <= 1'b0;
            cap_q       <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            cnt_q       <= 2'd0;
            rank_q      <= RANK_DEF;
            hold_q      <= 32'd0;
            new_q       <= 1'b0;
            seg_record  <= SEG_RST;
            led_record  <= LED_RST;
        end else begin
            state_q     <= state_d;
            gov_prev_q  <= gameover_infinity;
            show_prev_q <= btn_show;
            ret_prev_q  <= btn_return;
            cap_q       <= cap_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            cnt_q       <= cnt_d;
            rank_q      <= rank_d;
            hold_q      <= hold_d;
            new_q       <= new_d;
            seg_record  <= seg_d;
            led_record  <= led_d;
        end
    end
endmodule

// File: tb/tb_score_record_infinity.sv
// tb_score_record_infinity: directed table-driven bench for the score record block
module tb_score_record_infinity;
    import score_record_infinity_pkg::*;

    logic        clk = 1'b0;
    logic        rst, gameover_infinity, btn_show, btn_return;
    logic [5:0]  score_infinity;
    logic [15:0] seg_record, led_record;
    logic        new_record, busy;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [5:0]  score;
        logic [5:0]  r1, r2, r3;
        logic        nr;
        logic [15:0] seg;
    } vec_t;
    vec_t vecs[8];

    score_record_infinity #(.CLR_HOLD(8), .SHOW_DEFAULT(0)) dut (
        .clk(clk), .rst(rst), .gameover_infinity(gameover_infinity),
        .score_infinity(score_infinity), .btn_show(btn_show), .btn_return(btn_return),
        .seg_record(seg_record), .led_record(led_record),
        .new_record(new_record), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic play(input logic [5:0] s);
        @(negedge clk);
        score_infinity = s;
        gameover_infinity = 1'b1;
        @(negedge clk);
        @(negedge clk);
        gameover_infinity = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic show_step();
        @(negedge clk);
        btn_show = 1'b1;
        @(negedge clk);
        btn_show = 1'b0;
        @(negedge clk);
    endtask

    task automatic hold_ret(input int n);
        @(negedge clk);
        btn_return = 1'b1;
        repeat (n) @(negedge clk);
        btn_return = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{6'd12, 6'd12, 6'd0,  6'd0,  1'b1, 16'h1012};
        vecs[1] = '{6'd30, 6'd30, 6'd12, 6'd0,  1'b1, 16'h1030};
        vecs[2] = '{6'd7,  6'd30, 6'd12, 6'd7,  1'b0, 16'h1030};
        vecs[3] = '{6'd30, 6'd30, 6'd30, 6'd12, 1'b0, 16'h1030};
        vecs[4] = '{6'd5,  6'd30, 6'd30, 6'd12, 1'b0, 16'h1030};
        vecs[5] = '{6'd63, 6'd63, 6'd30, 6'd30, 1'b1, 16'h1063};
        vecs[6] = '{6'd30, 6'd63, 6'd30, 6'd30, 1'b0, 16'h1063};
        vecs[7] = '{6'd31, 6'd63, 6'd31, 6'd30, 1'b0, 16'h1063};
        rst = 1'b1;
        gameover_infinity = 1'b0;
        btn_show = 1'b0;
        btn_return = 1'b0;
        score_infinity = 6'd0;
        repeat (2) @(negedge clk);
        chk("rst_seg", seg_record, 16'h1000);
        chk("rst_led", led_record, 16'h0001);
        chk("rst_new", new_record, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            play(vecs[i].score);
            chk($sformatf("v%0d_r1", i), dut.r1_q, vecs[i].r1);
            chk($sformatf("v%0d_r2", i), dut.r2_q, vecs[i].r2);
            chk($sformatf("v%0d_r3", i), dut.r3_q, vecs[i].r3);
            chk($sformatf("v%0d_new", i), new_record, vecs[i].nr);
            chk($sformatf("v%0d_seg", i), seg_record, vecs[i].seg);
            chk($sformatf("v%0d_led", i), led_record, {vecs[i].nr, 12'h000, 3'b001});
            if (i == 3) begin
                show_step();
                chk("show1_seg", seg_record, 16'h2030);
                chk("show1_led", led_record, 16'h0002);
                show_step();
                chk("show2_seg", seg_record, 16'h3012);
                chk("show2_led", led_record, 16'h0004);
                show_step();
                chk("show3_wrap", seg_record, 16'h1030);
            end
        end

        hold_ret(7);
        chk("hold7_r1", dut.r1_q, 6'd63);
        chk("hold7_cnt", dut.cnt_q, 2'd3);
        chk("hold7_seg", seg_record, 16'h1063);
        chk("hold7_state", 32'(dut.state_q), 32'(IDLE));
        hold_ret(8);
        chk("hold8_r1", dut.r1_q, 6'd0);
        chk("hold8_cnt", dut.cnt_q, 2'd0);
        chk("hold8_seg", seg_record, 16'h1000);

        @(negedge clk);
        score_infinity = 6'd0;
        gameover_infinity = 1'b1;
        @(negedge clk);
        @(negedge clk);
        gameover_infinity = 1'b0;
        btn_show = 1'b1;
        @(negedge clk);
        btn_show = 1'b0;
        @(negedge clk);
        chk("zero_rank", dut.rank_q, 2'd0);
        chk("zero_cnt", dut.cnt_q, 2'd1);
        chk("zero_r1", dut.r1_q, 6'd0);
        chk("zero_seg", seg_record, 16'h1000);
        chk("zero_led", led_record, 16'h8001);

        @(negedge clk);
        chk("t45_busy_pre", busy, 1'b0);
        score_infinity = 6'd45;
        gameover_infinity = 1'b1;
        @(negedge clk);
        chk("t45_busy1", busy, 1'b1);
        @(negedge clk);
        chk("t45_busy2", busy, 1'b1);
        gameover_infinity = 1'b0;
        @(negedge clk);
        chk("t45_busy3", busy, 1'b0);
        chk("t45_seg_old", seg_record, 16'h1000);
        @(negedge clk);
        chk("t45_seg", seg_record, 16'h1045);
        chk("t45_led", led_record, 16'h8001);
        chk("t45_r2", dut.r2_q, 6'd0);

        @(negedge clk);
        btn_return = 1'b1;
        @(negedge clk);
        btn_return = 1'b0;
        @(negedge clk);
        chk("ack_new", new_record, 1'b0);
        chk("ack_state", 32'(dut.state_q), 32'(IDLE));
        chk("ack_r1", dut.r1_q, 6'd45);

        @(negedge clk);
        score_infinity = 6'd50;
        gameover_infinity = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cap_state", 32'(dut.state_q), 32'(CAPTURE));
        rst = 1'b1;
        gameover_infinity = 1'b0;
        #1;
        chk("rst_cap_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cap_idle", 32'(dut.state_q), 32'(IDLE));
        chk("rst_cap_r1", dut.r1_q, 6'd0);
        chk("rst_cap_cnt", dut.cnt_q, 2'd0);
        chk("rst_cap_new", new_record, 1'b0);
        chk("rst_cap_seg", seg_record, 16'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
